gray_to_binary_conv: RTL and testbench
======================================

// Module: gray_to_binary_conv
// PURPOSE
// - Registered Gray-code to natural-binary converter.
// - Default width is 4 bits; the width is parameterizable.
// - Sits between Gray-coded sources (encoder counters, CDC pointers) and binary consumers.
// - Carries a valid qualifier so it drops into streaming paths.
// PARAMETERS
// - WIDTH  4  bit width of the Gray input and the binary output (>=1)
// PORTS
// - clk      in   1      rising-edge clock
// - rst_n    in   1      synchronous reset, active-low
// - g        in   WIDTH  Gray-coded input word
// - g_valid  in   1      g is valid this cycle
// - b        out  WIDTH  binary result (registered)
// - b_valid  out  1      b holds a fresh conversion
// Interface rule: one clock; reset is synchronous and active-low.
// BEHAVIOUR
// - Conversion:
//   - b[WIDTH-1] = g[WIDTH-1].
//   - b[i] = b[i+1] ^ g[i] for i = WIDTH-2 down to 0.
//   - Equivalently, b[i] is the XOR of g[WIDTH-1:i].
// - Width: output width equals input width. No carry and no truncation; all 2^WIDTH codes are legal.
// - Latency: 1 clk by default. The result for g sampled at edge N appears on b/b_valid after edge N.
// - Reset: on a clk edge with rst_n=0, b <= 0 and b_valid <= 0. Reset wins over a simultaneous g_valid=1.
// - Reset mid-operation: an in-flight word is discarded and never reported valid.
// - Valid=1: b_valid <= g_valid every cycle, and b is loaded with the conversion.
// - Valid=0: b holds its last value; only b_valid drops.
// - Handshake: no backpressure. One result per cycle at full throughput; back-to-back valid words are allowed.
// - Wrap-around: g 1000 -> b 1111 and g 0000 -> b 0000. No special handling.
// - X on g while g_valid=0 must not propagate into b.
// CONFIGURATION
// - Macro: GRAY_TO_BINARY_PIPE_EN.
// - Undefined (default): single register stage, latency 1.
// - Defined:
//   - The XOR prefix chain splits into two register stages.
//   - Stage 1 registers the upper ceil(WIDTH/2) binary bits plus the raw lower Gray bits.
//   - Stage 2 completes the lower bits.
//   - Latency becomes 2; b_valid is delayed to match.
//   - Reset clears both stages and both valid bits.
//   - Results are identical to the default build, delayed by 1 cycle.
// STRUCTURE
// - Package gray_pkg:
//   - localparam DEFAULT_GRAY_WIDTH = 4.
//   - Function gray2bin(logic [W-1:0]).
//   - Function bin2gray, used by the bench's reference model.
// - One sub-module, gray2bin_xor_chain: combinational prefix-XOR over a bit slice.
//   - It takes a carry-in bit so the pipelined build can chain two instances.
// - The top level holds only the valid/data registers and the macro-selected staging.
// TESTING
// - Reset: rst_n=0 for 2 clk with g=1111 and g_valid=1 -> b=0000, b_valid=0.
// - Single words (WIDTH=4), each held 1 cycle with g_valid=1; check b one cycle later:
//   - g=0001 -> b=0001
//   - g=0010 -> b=0011
//   - g=0011 -> b=0010
//   - g=0100 -> b=0111
//   - g=1010 -> b=1100
//   - g=1111 -> b=1010
// - Exhaustive stream: all 16 g codes back-to-back -> b equals gray2bin(g) each cycle and b_valid stays 1.
// - Gray sequence: drive bin2gray(0..15), then wrap to 0 -> b counts 0..15 then 0.
// - Hold: g_valid=0 while g changes -> b_valid=0 and b stays at the last result.
// - Mid-stream reset: assert rst_n=0 for 1 cycle between valid words -> that cycle yields no valid output.
// - Pipelined build: repeat all of the above with GRAY_TO_BINARY_PIPE_EN defined, expecting latency 2.
// - Width sweep: WIDTH=1 (b=g) and WIDTH=8 (g=8'hFF -> b=8'hAA).

Source files
------------

// File: rtl/gray_pkg.sv
// Shared constants and Gray/binary helper functions for the gray-to-binary converter.
package gray_pkg;

  localparam int DEFAULT_GRAY_WIDTH = 4;
  localparam int GRAY_MAX_W         = 32;

  // Helpers work on a zero-extended word: leading zeros do not change any XOR prefix.
  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b = g;
    for (int s = 1; s < GRAY_MAX_W; s = s << 1)
      b = b ^ (b >> s);
    return b;
  endfunction

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray2bin_xor_chain.sv
// Combinational prefix-XOR over a Gray slice; cin is the binary bit just above the slice.
module gray2bin_xor_chain #(
  parameter int W = 4
) (
  input  logic         cin,
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);

  logic acc;

  always_comb begin
    b   = '0;
    acc = cin;
    for (int i = W - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
  end

endmodule

// File: rtl/gray_to_binary_conv.sv
// Registered Gray-to-binary converter with valid qualifier.
// Define GRAY_TO_BINARY_PIPE_EN to split the XOR chain over two register stages (latency 2).
module gray_to_binary_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_GRAY_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] g,
  input  logic             g_valid,
  output logic [WIDTH-1:0] b,
  output logic             b_valid
);

`ifdef GRAY_TO_BINARY_PIPE_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  // vld_pipe[0] is the live input qualifier; higher taps are registered.
  logic [STAGES:0] vld_pipe;
  logic [STAGES:1] vld_q;

  assign vld_pipe = {vld_q, g_valid};
  assign b_valid  = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_pipe[STAGES-1:0];
  end

`ifdef GRAY_TO_BINARY_PIPE_EN
  localparam int HI_W = (WIDTH + 1) / 2;
  localparam int LO_W = WIDTH - HI_W;

  logic [HI_W-1:0] hi_bin;
  logic [HI_W-1:0] s1_hi;

  gray2bin_xor_chain #(.W(HI_W)) u_hi (
    .cin (1'b0),
    .g   (g[WIDTH-1 -: HI_W]),
    .b   (hi_bin)
  );

  // Registers load only on valid so an undriven g never reaches b.
  always_ff @(posedge clk) begin
    if (!rst_n)             s1_hi <= '0;
    else if (vld_pipe[0])   s1_hi <= hi_bin;
  end

  if (LO_W > 0) begin : g_lo
    logic [LO_W-1:0] s1_lo;
    logic [LO_W-1:0] lo_bin;

    always_ff @(posedge clk) begin
      if (!rst_n)           s1_lo <= '0;
      else if (vld_pipe[0]) s1_lo <= g[LO_W-1:0];
    end

    // Lower chain resumes from the last upper binary bit.
    gray2bin_xor_chain #(.W(LO_W)) u_lo (
      .cin (s1_hi[0]),
      .g   (s1_lo),
      .b   (lo_bin)
    );

    always_ff @(posedge clk) begin
      if (!rst_n)           b <= '0;
      else if (vld_pipe[1]) b <= {s1_hi, lo_bin};
    end
  end else begin : g_nolo
    always_ff @(posedge clk) begin
      if (!rst_n)           b <= '0;
      else if (vld_pipe[1]) b <= s1_hi;
    end
  end
`else
  logic [WIDTH-1:0] b_comb;

  gray2bin_xor_chain #(.W(WIDTH)) u_chain (
    .cin (1'b0),
    .g   (g),
    .b   (b_comb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)           b <= '0;
    else if (vld_pipe[0]) b <= b_comb;
  end
`endif

endmodule

// File: tb/tb_gray_to_binary_conv.sv
// Scoreboard bench for gray_to_binary_conv at WIDTH 1, 4 and 8 sharing one stimulus stream.
module tb_gray_to_binary_conv;
  import gray_pkg::*;

`ifdef GRAY_TO_BINARY_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       g_valid;
  logic [7:0] gin;
  logic [0:0] b1;
  logic [3:0] b4;
  logic [7:0] b8;
  logic       bv1, bv4, bv8;

  always #5 clk = ~clk;

  gray_to_binary_conv #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .g(gin[0:0]), .g_valid(g_valid), .b(b1), .b_valid(bv1));
  gray_to_binary_conv #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .g(gin[3:0]), .g_valid(g_valid), .b(b4), .b_valid(bv4));
  gray_to_binary_conv #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .g(gin), .g_valid(g_valid), .b(b8), .b_valid(bv8));

  typedef struct {
    logic [0:0] e1;
    logic [3:0] e4;
    logic [7:0] e8;
    int         due;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference: invert Gray coding by searching for the binary value whose code matches.
  function automatic logic [7:0] ref_bin(input logic [7:0] gw, input int w);
    gray_word_t code;
    logic [7:0] mask;
    mask = 8'((1 << w) - 1);
    for (int n = 0; n < (1 << w); n++) begin
      code = bin2gray(gray_word_t'(n));
      if ((code[7:0] & mask) == (gw & mask)) return 8'(n);
    end
    return 8'hEE;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: sample inputs at the edge, as the DUT does.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      q.delete();
      last.e1 = '0; last.e4 = '0; last.e8 = '0;
    end else if (g_valid) begin
      e.e1  = ref_bin(gin, 1) == 8'd1;
      e.e4  = ref_bin(gin, 4)[3:0];
      e.e8  = ref_bin(gin, 8);
      e.due = cyc + LAT - 1;
      q.push_back(e);
    end
  end

  // Monitor: valid must appear exactly when an entry is due; otherwise b holds.
  always @(negedge clk) begin
    if (cyc > 0) begin
      logic want_v;
      want_v = (q.size() > 0) && (q[0].due == cyc);
      check("b_valid", {29'd0, bv1, bv4, bv8}, {29'd0, {3{want_v}}});
      if (want_v) last = q.pop_front();
      check("b_w1", 32'(b1), 32'(last.e1));
      check("b_w4", 32'(b4), 32'(last.e4));
      check("b_w8", 32'(b8), 32'(last.e8));
    end
  end

  task automatic drive(input logic r, input logic v, input logic [7:0] gw);
    rst_n   = r;
    g_valid = v;
    gin     = gw;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] singles [6] = '{8'h01, 8'h32, 8'h93, 8'h04, 8'h5A, 8'hFF};

  initial begin
    gray_word_t gc;
    // Reset with a valid all-ones word present: reset must win.
    drive(1'b0, 1'b1, 8'hFF);
    drive(1'b0, 1'b1, 8'hFF);
    check("reset_b4", 32'(b4), 32'd0);
    check("reset_bv4", 32'(bv4), 32'd0);

    foreach (singles[i]) begin
      drive(1'b1, 1'b1, singles[i]);
      drive(1'b1, 1'b0, 8'($urandom));
      drive(1'b1, 1'b0, 8'($urandom));
    end

    for (int i = 0; i < 16; i++)
      drive(1'b1, 1'b1, 8'(($urandom_range(0, 15) << 4) | i));

    for (int i = 0; i <= 16; i++) begin
      gc = bin2gray(gray_word_t'(i % 16));
      drive(1'b1, 1'b1, gc[7:0]);
    end

    drive(1'b1, 1'b1, 8'h5A);
    repeat (4) drive(1'b1, 1'b0, 8'($urandom));

    drive(1'b1, 1'b1, 8'($urandom));
    drive(1'b1, 1'b1, 8'($urandom));
    drive(1'b0, 1'b1, 8'($urandom));
    drive(1'b1, 1'b1, 8'($urandom));
    drive(1'b1, 1'b1, 8'($urandom));

    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 3) != 0), 8'($urandom));

    repeat (LAT + 3) drive(1'b1, 1'b0, 8'($urandom));
    @(negedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
